pipeline_branch_sequencer: RTL and testbench

Sequencing unit on the far side of the pipeline controller's `branch_status`/`want_stall`/`jump_start` interface. It produces the 2-bit `branch_status` that steps a control-flow instruction through a multi-cycle redirect sequence. It also raises `want_stall` for load-use hazards and data-memory wait. It sits beside the controller in the decode stage and keeps a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipeline_branch_sequencer_if.sv | 31 +++
 rtl/pipeline_branch_sequencer.sv | 87 ++++++++
 tb/tb_pipeline_branch_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_branch_sequencer_if.sv
// Decode-side bundle between the pipeline controller and the branch sequencer.
// The controller side uses master; the sequencer uses slave.
interface pipeline_branch_sequencer_if #(
  parameter int COUNT_WIDTH = 32
);
  logic                   jump_start;
  logic                   flush;
  logic                   ex_mem_read;
  logic [4:0]             ex_rd;
  logic [4:0]             id_rs1;
  logic [4:0]             id_rs2;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic                   data_mem_wait;
  logic [1:0]             branch_status;
  logic                   want_stall;
  logic                   fetch_squash;
  logic [COUNT_WIDTH-1:0] stall_cycles;

  modport master (
    output jump_start, flush, ex_mem_read, ex_rd, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, data_mem_wait,
    input  branch_status, want_stall, fetch_squash, stall_cycles
  );

  modport slave (
    input  jump_start, flush, ex_mem_read, ex_rd, id_rs1, id_rs2,
           id_uses_rs1, id_uses_rs2, data_mem_wait,
    output branch_status, want_stall, fetch_squash, stall_cycles
  );
endinterface

// File: rtl/pipeline_branch_sequencer.sv
// Steps a control-flow instruction through WAIT/REDIRECT, raises load-use and
// memory-wait stalls in IDLE, and keeps a saturating stall-cycle counter.
module pipeline_branch_sequencer #(
  parameter int JUMP_LATENCY = 2,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  pipeline_branch_sequencer_if.slave    bus
);

  // State encoding doubles as branch_status: bit0 = PC update, bit1 = decode advance.
  typedef enum logic [1:0] {
    S_IDLE     = 2'b00,
    S_WAIT     = 2'b10,
    S_REDIRECT = 2'b01
  } state_t;

  localparam logic [3:0] LP_LOAD = 4'(JUMP_LATENCY - 1);

  state_t                 r_state;
  logic [3:0]             r_cnt;
  logic                   r_fetch_squash;
  logic [COUNT_WIDTH-1:0] r_stall_cycles;

  logic w_hazard;
  logic w_want_stall;

  assign w_hazard = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // Stalling mid-sequence would let the controller override break the redirect.
  assign w_want_stall = (r_state == S_IDLE) && !i_reset &&
                        (w_hazard || bus.data_mem_wait);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= 4'd0;
      r_fetch_squash <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      if (w_want_stall && (r_stall_cycles != {COUNT_WIDTH{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end

      if (bus.flush) begin
        r_state        <= S_IDLE;
        r_cnt          <= 4'd0;
        r_fetch_squash <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.jump_start) begin
              r_state        <= S_WAIT;
              r_cnt          <= LP_LOAD;
              r_fetch_squash <= 1'b1;
            end
          end
          S_WAIT: begin
            if (r_cnt == 4'd0) begin
              r_state <= S_REDIRECT;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          S_REDIRECT: begin
            r_state        <= S_IDLE;
            r_fetch_squash <= 1'b0;
          end
          default: begin
            r_state        <= S_IDLE;
            r_cnt          <= 4'd0;
            r_fetch_squash <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.branch_status = r_state;
  assign bus.fetch_squash  = r_fetch_squash;
  assign bus.want_stall    = w_want_stall;
  assign bus.stall_cycles  = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_branch_sequencer.sv
// Directed bench: default instance (latency 2, 32-bit count) and a narrow
// instance (latency 1, 4-bit count) share clock and reset.
module tb_pipeline_branch_sequencer;

  logic clock;
  logic reset;

  int n_checks = 0;
  int n_fail   = 0;

  pipeline_branch_sequencer_if #(.COUNT_WIDTH(32)) bus  ();
  pipeline_branch_sequencer_if #(.COUNT_WIDTH(4))  bus4 ();

  pipeline_branch_sequencer #(.JUMP_LATENCY(2), .COUNT_WIDTH(32)) dut (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus.slave)
  );

  pipeline_branch_sequencer #(.JUMP_LATENCY(1), .COUNT_WIDTH(4)) dut4 (
    .i_clock (clock),
    .i_reset (reset),
    .bus     (bus4.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.jump_start = 0; bus.flush = 0; bus.ex_mem_read = 0; bus.ex_rd = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.data_mem_wait = 0;
    bus4.jump_start = 0; bus4.flush = 0; bus4.ex_mem_read = 0; bus4.ex_rd = 0;
    bus4.id_rs1 = 0; bus4.id_rs2 = 0; bus4.id_uses_rs1 = 0; bus4.id_uses_rs2 = 0;
    bus4.data_mem_wait = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    bus.jump_start = 1; bus.flush = 1; bus.ex_mem_read = 1; bus.ex_rd = 5'h1F;
    bus.id_rs1 = 5'h1F; bus.id_rs2 = 5'h1F; bus.id_uses_rs1 = 1; bus.id_uses_rs2 = 1;
    bus.data_mem_wait = 1;
    tick(); tick();
    n_checks++; if (bus.branch_status !== 2'b00) begin n_fail++; $display("FAIL reset_status: got %b expected 00", bus.branch_status); end
    n_checks++; if (bus.want_stall !== 1'b0) begin n_fail++; $display("FAIL reset_want_stall: got %b expected 0", bus.want_stall); end
    n_checks++; if (bus.fetch_squash !== 1'b0) begin n_fail++; $display("FAIL reset_squash: got %b expected 0", bus.fetch_squash); end
    n_checks++; if (bus.stall_cycles !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.stall_cycles); end
    n_checks++; if (bus4.stall_cycles !== 4'd0) begin n_fail++; $display("FAIL reset_count4: got %0d expected 0", bus4.stall_cycles); end
    // Release with jump_start still high; everything else quiet.
    reset = 0;
    bus.flush = 0; bus.ex_mem_read = 0; bus.data_mem_wait = 0;
    bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    tick();
    n_checks++; if (bus.branch_status !== 2'b10) begin n_fail++; $display("FAIL release_jump: got %b expected 10", bus.branch_status); end
    bus.jump_start = 0;
    bus.flush = 1;
    tick();
    bus.flush = 0;
    n_checks++; if (bus.branch_status !== 2'b00) begin n_fail++; $display("FAIL release_flush: got %b expected 00", bus.branch_status); end
  endtask

  task automatic test_jump_sequence();
    logic [1:0] exp_st [4] = '{2'b10, 2'b10, 2'b01, 2'b00};
    logic       exp_sq [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bus.jump_start = 1;
    tick();
    bus.jump_start = 0;
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (bus.branch_status !== exp_st[i]) begin n_fail++; $display("FAIL jump_status[%0d]: got %b expected %b", i, bus.branch_status, exp_st[i]); end
      n_checks++; if (bus.fetch_squash !== exp_sq[i]) begin n_fail++; $display("FAIL jump_squash[%0d]: got %b expected %b", i, bus.fetch_squash, exp_sq[i]); end
      tick();
    end
  endtask

  task automatic test_jump_latency1();
    logic [1:0] exp_st [3] = '{2'b10, 2'b01, 2'b00};
    bus4.jump_start = 1;
    tick();
    bus4.jump_start = 0;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (bus4.branch_status !== exp_st[i]) begin n_fail++; $display("FAIL lat1_status[%0d]: got %b expected %b", i, bus4.branch_status, exp_st[i]); end
      tick();
    end
  endtask

  task automatic test_load_use();
    bus.ex_mem_read = 1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1;
    bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1;
    #1;
    n_checks++; if (bus.want_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_rs2: got %b expected 1", bus.want_stall); end
    bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
    #1;
    n_checks++; if (bus.want_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_x0: got %b expected 0", bus.want_stall); end
    bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 0;
    #1;
    n_checks++; if (bus.want_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_unused: got %b expected 0", bus.want_stall); end
    bus.id_rs1 = 5'd5;
    #1;
    n_checks++; if (bus.want_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_rs1: got %b expected 1", bus.want_stall); end
    bus.ex_mem_read = 0;
    #1;
    n_checks++; if (bus.want_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_noload: got %b expected 0", bus.want_stall); end
    clear_inputs();
    tick();
  endtask

  task automatic test_data_mem_wait();
    bus.data_mem_wait = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++; if (bus.want_stall !== 1'b1) begin n_fail++; $display("FAIL memwait_stall[%0d]: got %b expected 1", i, bus.want_stall); end
      tick();
    end
    bus.data_mem_wait = 0;
    #1;
    n_checks++; if (bus.want_stall !== 1'b0) begin n_fail++; $display("FAIL memwait_drop: got %b expected 0", bus.want_stall); end
    n_checks++; if (bus.stall_cycles !== 32'd4) begin n_fail++; $display("FAIL memwait_count: got %0d expected 4", bus.stall_cycles); end
    bus.jump_start = 1;
    tick();
    bus.jump_start = 0;
    bus.data_mem_wait = 1;
    #1;
    n_checks++; if (bus.want_stall !== 1'b0) begin n_fail++; $display("FAIL wait1_stall: got %b expected 0", bus.want_stall); end
    tick();
    n_checks++; if (bus.want_stall !== 1'b0) begin n_fail++; $display("FAIL wait2_stall: got %b expected 0", bus.want_stall); end
    tick();
    n_checks++; if (bus.want_stall !== 1'b0 || bus.branch_status !== 2'b01) begin n_fail++; $display("FAIL redirect_stall: got stall %b status %b expected 0/01", bus.want_stall, bus.branch_status); end
    bus.data_mem_wait = 0;
    tick();
    n_checks++; if (bus.stall_cycles !== 32'd4) begin n_fail++; $display("FAIL seq_count: got %0d expected 4", bus.stall_cycles); end
    n_checks++; if (bus.branch_status !== 2'b00) begin n_fail++; $display("FAIL seq_end_status: got %b expected 00", bus.branch_status); end
  endtask

  task automatic test_flush();
    bus.jump_start = 1;
    tick();
    bus.jump_start = 0;
    n_checks++; if (bus.branch_status !== 2'b10) begin n_fail++; $display("FAIL flush_pre: got %b expected 10", bus.branch_status); end
    bus.flush = 1;
    tick();
    bus.flush = 0;
    n_checks++; if (bus.branch_status !== 2'b00 || bus.fetch_squash !== 1'b0) begin n_fail++; $display("FAIL flush_wait: got status %b squash %b expected 00/0", bus.branch_status, bus.fetch_squash); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (bus.branch_status !== 2'b00) begin n_fail++; $display("FAIL flush_no_redirect[%0d]: got %b expected 00", i, bus.branch_status); end
    end
    bus.flush = 1; bus.jump_start = 1;
    tick();
    bus.flush = 0; bus.jump_start = 0;
    n_checks++; if (bus.branch_status !== 2'b00 || bus.fetch_squash !== 1'b0) begin n_fail++; $display("FAIL flush_vs_jump: got status %b squash %b expected 00/0", bus.branch_status, bus.fetch_squash); end
    tick();
    n_checks++; if (bus.branch_status !== 2'b00) begin n_fail++; $display("FAIL flush_vs_jump_after: got %b expected 00", bus.branch_status); end
  endtask

  task automatic test_saturation();
    bus4.data_mem_wait = 1;
    for (int i = 0; i < 14; i++) tick();
    n_checks++; if (bus4.stall_cycles !== 4'd14) begin n_fail++; $display("FAIL sat_pre: got %0d expected 14", bus4.stall_cycles); end
    for (int i = 0; i < 6; i++) tick();
    n_checks++; if (bus4.stall_cycles !== 4'd15) begin n_fail++; $display("FAIL sat_hold: got %0d expected 15", bus4.stall_cycles); end
    n_checks++; if (bus4.want_stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall: got %b expected 1", bus4.want_stall); end
    bus4.data_mem_wait = 0;
    tick();
  endtask

  task automatic test_reset_mid_sequence();
    bus.jump_start = 1;
    tick();
    bus.jump_start = 0;
    reset = 1;
    tick();
    reset = 0;
    n_checks++; if (bus.branch_status !== 2'b00 || bus.fetch_squash !== 1'b0) begin n_fail++; $display("FAIL reset_mid: got status %b squash %b expected 00/0", bus.branch_status, bus.fetch_squash); end
    tick();
    n_checks++; if (bus.branch_status !== 2'b00) begin n_fail++; $display("FAIL reset_mid_after: got %b expected 00", bus.branch_status); end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    test_reset();
    test_jump_sequence();
    test_jump_latency1();
    test_load_use();
    test_data_mem_wait();
    test_flush();
    test_saturation();
    test_reset_mid_sequence();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
